fetch_trace_queue: RTL and testbench
====================================

// Module: fetch_trace_queue
// PURPOSE
//  Multi-entry successor of the single-slot fetch-stage tracker. Sits between the
//  first fetch stage (request side) and decode. Holds up to DEPTH outstanding
//  instruction-bus requests with their exception info and prediction metadata.
//  Retires them in order against inst_data_ok, and suppresses output for entries
//  canceled by a redirect while the request was in flight.
// PARAMETERS
//  DEPTH      4    outstanding entries; any value >= 2, not restricted to powers of two
//  PAYLOAD_W  256  packed BTB/RAS/PHT metadata per entry, carried opaquely
//  EXC_W      5    exception code width
// PORTS
//  clk            in   1          clock
//  rst            in   1          asynchronous reset, active-low
//  req_valid_i    in   1          request accepted by the bus this cycle; push when allowin_o
//  req_vaddr_i    in   32         fetch virtual address
//  req_payload_i  in   PAYLOAD_W  prediction metadata
//  req_has_exc_i  in   1          exception raised upstream
//  req_exc_code_i in   EXC_W      upstream exception code
//  mmu_has_exc_i  in   1          MMU exception for this address
//  mmu_exc_code_i in   EXC_W      MMU exception code
//  mmu_is_refill_i in  1          MMU exception is a TLB refill
//  cancel_i       in   1          OR of branch-mismatch, CP0 exception and branch-recovery flush
//  inst_data_ok   in   1          in-order bus response for the oldest bus-waiting entry
//  allowin_o      out  1          room for a push this cycle
//  out_valid_o    out  1          one-cycle pulse: head retires un-canceled
//  out_vaddr_o    out  32         head vaddr
//  out_payload_o  out  PAYLOAD_W  head metadata
//  out_has_exc_o  out  1          head exception flag
//  out_exc_code_o out  EXC_W      head exception code
//  out_is_refill_o out 1          head refill flag
//  count_o        out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  - Circular buffer. wr_ptr/rd_ptr wrap from DEPTH-1 to 0. Occupancy held in count.
//  - Reset (async, rst=0): count=0, ptrs=0, all cancel bits=0, credit=0.
//    All out_* are 0 and allowin_o=1.
//  - Exception merge at push:
//      has_exc  = req_has_exc | mmu_has_exc
//      code     = req_has_exc ? req_exc_code : mmu_exc_code
//      is_refill = ~req_has_exc & mmu_is_refill
//  - pop: count!=0 and the head completes (see CONFIGURATION). At most one pop per cycle.
//  - allowin_o = (count<DEPTH) | pop. Full plus a pop in the same cycle accepts a push.
//  - push = req_valid_i & allowin_o. count_next = count + push - pop.
//  - out_* are combinational from the head entry and forced to 0 when count==0.
//  - out_valid_o = pop & ~head.canceled. Decode accepts it unconditionally; there is no back-pressure.
//  - cancel_i sets the canceled bit of every stored entry and of an entry pushed in the same cycle.
//  - Canceled entries still wait for their bus response (no abort). They then pop with out_valid_o=0.
//  - No same-cycle bypass: an entry pushed in cycle N can pop at N+1 at the earliest.
//  - inst_data_ok with no bus-waiting entry is a protocol error. It is ignored and state is unchanged.
//    Flag it with a simulation-only assertion.
//  - Reset during traffic discards every entry. Late bus responses after reset are protocol errors.
// CONFIGURATION
//  Macro FTQ_EXC_BYPASS_EN.
//  Undefined: the bus sees every entry. The head pops only on inst_data_ok, exception entries included.
//  Defined: exception entries issue no bus request and pop as soon as they reach the head.
//    An extra credit counter, range 0..DEPTH, holds an inst_data_ok that arrives while the head
//    is an exception entry.
//    A non-exception head pops when inst_data_ok or credit!=0.
//    Credit increments on an unused inst_data_ok and decrements on a non-exception pop;
//    both in the same cycle leave it unchanged.
// TESTING
//  T1 reset: hold rst=0 mid-traffic -> count_o=0, out_valid_o=0, allowin_o=1 within the same cycle.
//  T2 fill: DEPTH=4, 4 pushes (vaddr 0x1000..0x100C), no data_ok -> allowin_o=0;
//     then data_ok with a push -> out_vaddr_o=0x1000 pulses, new entry stored, count_o stays 4.
//  T3 cancel: 3 entries, cancel_i for one cycle, then 3 data_ok
//     -> 3 pops, out_valid_o never 1, count_o 3->0.
//  T4 cancel+push same cycle: the pushed entry is also canceled; a following push is not and retires with out_valid_o=1.
//  T5 exc merge: req_has_exc=1 code=4 and mmu code=2, refill=1 -> out_exc_code_o=4, out_is_refill_o=0.
//     mmu-only case -> code 2, refill 1.
//  T6 FTQ_EXC_BYPASS_EN: head exc entry plus a normal entry behind it; data_ok on cycle 1
//     -> exc pops on cycle 1, credit=1, normal entry pops on cycle 2 without data_ok.
//     Undefined macro -> exc waits for data_ok.

Source files
------------

// File: rtl/fetch_trace_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_trace_queue
//  Brief    : In-order tracker for up to DEPTH outstanding instruction-bus
//             fetch requests between the first fetch stage and decode.
//             Carries exception info and opaque prediction metadata, retires
//             entries against inst_data_ok and squashes output for entries
//             canceled by a redirect while in flight.
//  Options  : FTQ_EXC_BYPASS_EN - exception entries skip the bus and retire
//             as soon as they reach the head; early bus responses are held
//             in a credit counter.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_trace_queue #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 256,
  parameter int EXC_W     = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid_i,
  input  logic [31:0]                  req_vaddr_i,
  input  logic [PAYLOAD_W-1:0]         req_payload_i,
  input  logic                         req_has_exc_i,
  input  logic [EXC_W-1:0]             req_exc_code_i,
  input  logic                         mmu_has_exc_i,
  input  logic [EXC_W-1:0]             mmu_exc_code_i,
  input  logic                         mmu_is_refill_i,
  input  logic                         cancel_i,
  input  logic                         inst_data_ok,
  output logic                         allowin_o,
  output logic                         out_valid_o,
  output logic [31:0]                  out_vaddr_o,
  output logic [PAYLOAD_W-1:0]         out_payload_o,
  output logic                         out_has_exc_o,
  output logic [EXC_W-1:0]             out_exc_code_o,
  output logic                         out_is_refill_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH-1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry storage (no reset needed: only slots below count are ever read)
  logic [31:0]          vaddr_q   [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [EXC_W-1:0]     exc_code_q[DEPTH];
  logic [DEPTH-1:0]     has_exc_q;
  logic [DEPTH-1:0]     is_refill_q;

  // Control state
  logic [DEPTH-1:0] canceled_q, canceled_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             not_empty;
  logic             head_exc;
  logic             ok_legal;
  logic             ok_used;
  logic             pop;
  logic             push;
  logic             merged_exc;
  logic [EXC_W-1:0] merged_code;
  logic             merged_refill;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  // Upstream exception takes priority; refill only qualifies an MMU-only fault
  assign merged_exc    = req_has_exc_i | mmu_has_exc_i;
  assign merged_code   = req_has_exc_i ? req_exc_code_i : mmu_exc_code_i;
  assign merged_refill = ~req_has_exc_i & mmu_is_refill_i;

  assign not_empty = (count_q != '0);
  assign head_exc  = not_empty & has_exc_q[rd_ptr_q];
  assign ok_used   = inst_data_ok & ok_legal;

`ifdef FTQ_EXC_BYPASS_EN
  // credit: bus responses received ahead of their entry reaching the head
  // nexc  : stored entries that did issue a bus request
  logic [CW-1:0] credit_q, credit_d;
  logic [CW-1:0] nexc_q, nexc_d;

  assign ok_legal = (nexc_q > credit_q);
  assign pop      = not_empty & (head_exc | ok_used | (credit_q != '0));

  // A response always banks one credit; a non-exception retire spends one
  always_comb begin
    credit_d = credit_q + CW'(ok_used) - CW'(pop & ~head_exc);
    nexc_d   = nexc_q + CW'(push & ~merged_exc) - CW'(pop & ~head_exc);
  end
`else
  assign ok_legal = not_empty;
  assign pop      = ok_used;
`endif

  assign allowin_o = (count_q < FULL_CNT) | pop;
  assign push      = req_valid_i & allowin_o;

  // Pointer, occupancy and cancel-bit next state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    canceled_d = canceled_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (cancel_i) canceled_d = '1;
    if (push) canceled_d[wr_ptr_q] = cancel_i;
  end

  // Control registers, cleared by the asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      canceled_q <= '0;
`ifdef FTQ_EXC_BYPASS_EN
      credit_q   <= '0;
      nexc_q     <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      canceled_q <= canceled_d;
`ifdef FTQ_EXC_BYPASS_EN
      credit_q   <= credit_d;
      nexc_q     <= nexc_d;
`endif
    end
  end

  // Capture the pushed request into the tail slot
  always_ff @(posedge clk) begin
    if (push) begin
      vaddr_q[wr_ptr_q]     <= req_vaddr_i;
      payload_q[wr_ptr_q]   <= req_payload_i;
      exc_code_q[wr_ptr_q]  <= merged_code;
      has_exc_q[wr_ptr_q]   <= merged_exc;
      is_refill_q[wr_ptr_q] <= merged_refill;
    end
  end

  assign out_valid_o     = pop & ~canceled_q[rd_ptr_q];
  assign out_vaddr_o     = not_empty ? vaddr_q[rd_ptr_q]    : '0;
  assign out_payload_o   = not_empty ? payload_q[rd_ptr_q]  : '0;
  assign out_has_exc_o   = head_exc;
  assign out_exc_code_o  = not_empty ? exc_code_q[rd_ptr_q] : '0;
  assign out_is_refill_o = not_empty & is_refill_q[rd_ptr_q];
  assign count_o         = count_q;

`ifndef SYNTHESIS
  // A bus response with nothing waiting on the bus is a protocol error
  assert property (@(posedge clk) disable iff (!rst) !(inst_data_ok && !ok_legal))
    else $error("fetch_trace_queue: inst_data_ok with no bus-waiting entry");
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_trace_queue.sv
`default_nettype none
module tb_fetch_trace_queue;

  localparam int DEPTH = 4;
  localparam int PLW   = 256;
  localparam int EW    = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid_i;
  logic [31:0]    req_vaddr_i;
  logic [PLW-1:0] req_payload_i;
  logic           req_has_exc_i;
  logic [EW-1:0]  req_exc_code_i;
  logic           mmu_has_exc_i;
  logic [EW-1:0]  mmu_exc_code_i;
  logic           mmu_is_refill_i;
  logic           cancel_i;
  logic           inst_data_ok;
  logic           allowin_o;
  logic           out_valid_o;
  logic [31:0]    out_vaddr_o;
  logic [PLW-1:0] out_payload_o;
  logic           out_has_exc_o;
  logic [EW-1:0]  out_exc_code_o;
  logic           out_is_refill_o;
  logic [2:0]     count_o;

  always #5 clk = ~clk;

  fetch_trace_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PLW), .EXC_W(EW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_vaddr_i(req_vaddr_i), .req_payload_i(req_payload_i),
    .req_has_exc_i(req_has_exc_i), .req_exc_code_i(req_exc_code_i),
    .mmu_has_exc_i(mmu_has_exc_i), .mmu_exc_code_i(mmu_exc_code_i),
    .mmu_is_refill_i(mmu_is_refill_i), .cancel_i(cancel_i), .inst_data_ok(inst_data_ok),
    .allowin_o(allowin_o), .out_valid_o(out_valid_o), .out_vaddr_o(out_vaddr_o),
    .out_payload_o(out_payload_o), .out_has_exc_o(out_has_exc_o),
    .out_exc_code_o(out_exc_code_o), .out_is_refill_o(out_is_refill_o), .count_o(count_o)
  );

  // Reference model: an ordered list of in-flight fetches
  typedef struct {
    logic [31:0]    va;
    logic [PLW-1:0] pl;
    logic           exc;
    logic [EW-1:0]  code;
    logic           refill;
    logic           canc;
  } ent_t;

  ent_t mq[$];
  int   credit;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  bit   m_pop, m_push;

  task automatic chk(input string nm, input logic [PLW-1:0] act, input logic [PLW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Is a bus response allowed now (someone still waiting on the bus)?
  function automatic bit ok_legal();
`ifdef FTQ_EXC_BYPASS_EN
    int n = 0;
    foreach (mq[i]) if (!mq[i].exc) n++;
    return n > credit;
`else
    return mq.size() > 0;
`endif
  endfunction

  // Drive one cycle's inputs at the falling edge and compare against the model
  task automatic cyc_begin(input bit v, input logic [31:0] va, input logic rhe,
                           input logic [EW-1:0] rc, input logic me, input logic [EW-1:0] mc,
                           input logic mr, input logic can, input logic ok);
    @(negedge clk);
    req_valid_i = v;  req_vaddr_i = va;
    for (int i = 0; i < PLW/32; i++) req_payload_i[i*32 +: 32] = $urandom;
    req_has_exc_i = rhe; req_exc_code_i = rc;
    mmu_has_exc_i = me;  mmu_exc_code_i = mc; mmu_is_refill_i = mr;
    cancel_i = can; inst_data_ok = ok;
    #1;
`ifdef FTQ_EXC_BYPASS_EN
    m_pop = (mq.size() > 0) && (ok || mq[0].exc || credit > 0);
`else
    m_pop = (mq.size() > 0) && ok;
`endif
    m_push = v && (mq.size() < DEPTH || m_pop);
    chk("allowin", allowin_o, (mq.size() < DEPTH) || m_pop);
    chk("count", count_o, mq.size());
    if (mq.size() > 0) begin
      chk("out_valid", out_valid_o, m_pop && !mq[0].canc);
      chk("vaddr", out_vaddr_o, mq[0].va);
      chk("payload", out_payload_o, mq[0].pl);
      chk("has_exc", out_has_exc_o, mq[0].exc);
      chk("exc_code", out_exc_code_o, mq[0].code);
      chk("refill", out_is_refill_o, mq[0].refill);
    end else begin
      chk("out_valid", out_valid_o, 0);
      chk("vaddr", out_vaddr_o, 0);
      chk("payload", out_payload_o, 0);
      chk("has_exc", out_has_exc_o, 0);
      chk("exc_code", out_exc_code_o, 0);
      chk("refill", out_is_refill_o, 0);
    end
  endtask

  // Advance the model across the rising edge
  task automatic cyc_end();
    ent_t e;
    bit   nx = 0;
    @(posedge clk);
    if (m_pop) begin
      nx = !mq[0].exc;
      void'(mq.pop_front());
    end
`ifdef FTQ_EXC_BYPASS_EN
    credit = credit + (inst_data_ok ? 1 : 0) - ((m_pop && nx) ? 1 : 0);
`endif
    if (cancel_i) foreach (mq[i]) mq[i].canc = 1'b1;
    if (m_push) begin
      e.va     = req_vaddr_i;
      e.pl     = req_payload_i;
      e.exc    = req_has_exc_i | mmu_has_exc_i;
      e.code   = req_has_exc_i ? req_exc_code_i : mmu_exc_code_i;
      e.refill = !req_has_exc_i && mmu_is_refill_i;
      e.canc   = cancel_i;
      mq.push_back(e);
    end
  endtask

  task automatic push_n(input logic [31:0] va, input logic can, input logic ok);
    cyc_begin(1, va, 0, 0, 0, 0, 0, can, ok);
    cyc_end();
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      cyc_begin(0, 0, 0, 0, 0, 0, 0, 0, ok_legal());
      cyc_end();
    end
    #1;
    chk("drain_empty", count_o, 0);
  endtask

  task automatic zero_inputs();
    req_valid_i = 0; req_vaddr_i = 0; req_payload_i = '0;
    req_has_exc_i = 0; req_exc_code_i = 0; mmu_has_exc_i = 0;
    mmu_exc_code_i = 0; mmu_is_refill_i = 0; cancel_i = 0; inst_data_ok = 0;
  endtask

  initial begin
    rst = 0;
    credit = 0;
    zero_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", count_o, 0);
    chk("rst_allowin", allowin_o, 1);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_vaddr", out_vaddr_o, 0);
    rst = 1;

    // Fill to DEPTH, then pop and push together while full
    for (int i = 0; i < 4; i++) push_n(32'h1000 + 32'(4*i), 0, 0);
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("T2_full_allowin", allowin_o, 0);
    chk("T2_full_count", count_o, 4);
    cyc_end();
    cyc_begin(1, 32'h1010, 0, 0, 0, 0, 0, 0, 1);
    chk("T2_pop_valid", out_valid_o, 1);
    chk("T2_pop_vaddr", out_vaddr_o, 32'h1000);
    chk("T2_pop_allowin", allowin_o, 1);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("T2_count_stays", count_o, 4);
    chk("T2_next_head", out_vaddr_o, 32'h1004);
    cyc_end();
    drain();

    // Cancel squashes every stored entry
    for (int i = 0; i < 3; i++) push_n(32'h2000 + 32'(4*i), 0, 0);
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc_end();
    for (int i = 0; i < 3; i++) begin
      cyc_begin(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("T3_squashed", out_valid_o, 0);
      chk("T3_count", count_o, 3 - i);
      cyc_end();
    end
    #1;
    chk("T3_empty", count_o, 0);

    // Cancel together with a push squashes the pushed entry only
    push_n(32'h3000, 1, 0);
    push_n(32'h3004, 0, 0);
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("T4_canceled", out_valid_o, 0);
    chk("T4_canceled_va", out_vaddr_o, 32'h3000);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("T4_live", out_valid_o, 1);
    chk("T4_live_va", out_vaddr_o, 32'h3004);
    cyc_end();

    // Exception merge
    cyc_begin(1, 32'h4000, 1, 5'd4, 1, 5'd2, 1, 0, 0); cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0, ok_legal());
    chk("T5_req_exc", out_has_exc_o, 1);
    chk("T5_req_code", out_exc_code_o, 5'd4);
    chk("T5_req_refill", out_is_refill_o, 0);
    cyc_end();
    cyc_begin(1, 32'h4004, 0, 5'd4, 1, 5'd2, 1, 0, 0); cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0, ok_legal());
    chk("T5_mmu_code", out_exc_code_o, 5'd2);
    chk("T5_mmu_refill", out_is_refill_o, 1);
    cyc_end();
    drain();

    // Exception entry between two normal entries
    push_n(32'h5000, 0, 0);
    cyc_begin(1, 32'h5004, 1, 5'd3, 0, 0, 0, 0, 0); cyc_end();
    cyc_begin(1, 32'h5008, 0, 0, 0, 0, 0, 0, 1);
    chk("T6_n0_va", out_vaddr_o, 32'h5000);
    chk("T6_n0_valid", out_valid_o, 1);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("T6_exc_valid", out_valid_o, 1);
    chk("T6_exc_va", out_vaddr_o, 32'h5004);
    chk("T6_exc_flag", out_has_exc_o, 1);
    cyc_end();
    cyc_begin(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FTQ_EXC_BYPASS_EN
    chk("T6_credit_pop", out_valid_o, 1);
`else
    chk("T6_waits_ok", out_valid_o, 0);
`endif
    chk("T6_n1_va", out_vaddr_o, 32'h5008);
    chk("T6_count", count_o, 1);
    cyc_end();
    drain();

    // Randomized traffic with a reset in the middle
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        @(negedge clk);
        zero_inputs();
        rst = 0;
        #1;
        chk("T1_rst_count", count_o, 0);
        chk("T1_rst_valid", out_valid_o, 0);
        chk("T1_rst_allowin", allowin_o, 1);
        @(posedge clk);
        mq.delete();
        credit = 0;
        @(negedge clk);
        rst = 1;
      end
      cyc_begin(($urandom % 10) < 6, $urandom, ($urandom % 8) == 0, 5'($urandom),
                ($urandom % 8) == 0, 5'($urandom), $urandom % 2, ($urandom % 16) == 0,
                ok_legal() && ($urandom % 2 == 1));
      cyc_end();
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
